// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA copy engine.
// The FSM state encoding and the access step sizes are defined here.
package dma_pkg;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} dma_state_t;

  localparam int unsigned WORD_STEP = 4;
  localparam int unsigned BYTE_STEP = 1;

  // A word pair is only legal when both pointers are word aligned and a full word remains.
  function automatic logic use_word_step(input logic [1:0] src_lo,
                                         input logic [1:0] dst_lo,
                                         input logic       rem_ge_word);
    return (src_lo == 2'b00) && (dst_lo == 2'b00) && rem_ge_word;
  endfunction

endpackage

// File: rtl/dma_copy_engine_if.sv
// Data-memory port driven by the copy engine (master) and served by the memory (slave).
// Read data is combinational from addr_o/byte_op_o; writes commit on the falling clock edge.
interface dma_copy_engine_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  we_o;
  logic                  byte_op_o;
  logic [DATA_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] wd_o;
  logic [DATA_WIDTH-1:0] rd_i;

  modport master (output we_o, byte_op_o, addr_o, wd_o, input rd_i);
  modport slave  (input we_o, byte_op_o, addr_o, wd_o, output rd_i);
endinterface

// File: rtl/dma_range_check.sv
// Validates a copy request: both byte ranges inside the legal window and no forward overlap.
// Sums are one bit wider than the address so that a wrapping range is rejected.
module dma_range_check #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    LEN_WIDTH     = 16,
  parameter logic [DATA_WIDTH-1:0] START_ADDRESS = 'h10000,
  parameter logic [DATA_WIDTH-1:0] END_ADDRESS   = 'h1FFFF
) (
  input  logic [DATA_WIDTH-1:0] src,
  input  logic [DATA_WIDTH-1:0] dst,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  ok
);
  localparam int W = DATA_WIDTH + 1;

  logic [W-1:0] src_w, dst_w, len_w;
  logic [W-1:0] src_lim, src_end, dst_end;
  logic [W-1:0] lo, hi;
  logic         in_window, overlap;

  assign lo      = W'(START_ADDRESS);
  assign hi      = W'(END_ADDRESS);
  assign src_w   = {1'b0, src};
  assign dst_w   = {1'b0, dst};
  assign len_w   = W'(len);
  assign src_lim = src_w + len_w;
  assign src_end = src_lim - W'(1);
  assign dst_end = dst_w + len_w - W'(1);

  assign in_window = (src_w   >= lo) && (src_w   <= hi) &&
                     (src_end >= lo) && (src_end <= hi) &&
                     (dst_w   >= lo) && (dst_w   <= hi) &&
                     (dst_end >= lo) && (dst_end <= hi);

  // A destination starting inside the source would overwrite bytes before they are read.
  assign overlap = (src_w < dst_w) && (dst_w < src_lim);

  assign ok = in_window && !overlap;
endmodule

// File: rtl/dma_copy_engine.sv
// Second bus master on the data-memory port: copies len bytes from src to dst as
// read/write pairs, using word pairs when both pointers are aligned and byte pairs otherwise.
module dma_copy_engine
  import dma_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    BYTE_WIDTH    = 8,
  parameter logic [DATA_WIDTH-1:0] START_ADDRESS = 'h10000,
  parameter logic [DATA_WIDTH-1:0] END_ADDRESS   = 'h1FFFF,
  parameter int                    LEN_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] src_i,
  input  logic [DATA_WIDTH-1:0] dst_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  dma_copy_engine_if.master     mem
);

  dma_state_t            state_q, next_state;
  logic [DATA_WIDTH-1:0] src_q, dst_q, data_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic                  byte_q;
  logic                  busy_q, done_q, err_q;
  logic                  range_ok;

  logic [DATA_WIDTH-1:0] step, src_nxt, dst_nxt;
  logic [LEN_WIDTH-1:0]  step_len, rem_nxt;

  dma_range_check #(
    .DATA_WIDTH   (DATA_WIDTH),
    .LEN_WIDTH    (LEN_WIDTH),
    .START_ADDRESS(START_ADDRESS),
    .END_ADDRESS  (END_ADDRESS)
  ) u_range_check (
    .src(src_i),
    .dst(dst_i),
    .len(len_i),
    .ok (range_ok)
  );

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    step       = byte_q ? DATA_WIDTH'(BYTE_STEP) : DATA_WIDTH'(WORD_STEP);
    step_len   = byte_q ? LEN_WIDTH'(BYTE_STEP)  : LEN_WIDTH'(WORD_STEP);
    src_nxt    = src_q + step;
    dst_nxt    = dst_q + step;
    rem_nxt    = rem_q - step_len;
    next_state = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if ((len_i == '0) || !range_ok) next_state = DONE;
          else                            next_state = RD;
        end
      end
      RD:      next_state = WR;
      WR:      next_state = (rem_q == step_len) ? DONE : RD;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, so the bus never shows undefined values after reset.
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      byte_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= next_state;
      busy_q  <= (next_state == RD) || (next_state == WR);
      done_q  <= (next_state == DONE);
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            src_q  <= src_i;
            dst_q  <= dst_i;
            rem_q  <= len_i;
            err_q  <= (len_i != '0) && !range_ok;
            byte_q <= !use_word_step(src_i[1:0], dst_i[1:0],
                                     len_i >= LEN_WIDTH'(WORD_STEP));
          end
        end
        RD: begin
          data_q <= byte_q ? DATA_WIDTH'(mem.rd_i[BYTE_WIDTH-1:0]) : mem.rd_i;
        end
        WR: begin
          src_q  <= src_nxt;
          dst_q  <= dst_nxt;
          rem_q  <= rem_nxt;
          // Step for the following pair is fixed here, on entry to RD.
          byte_q <= !use_word_step(src_nxt[1:0], dst_nxt[1:0],
                                   rem_nxt >= LEN_WIDTH'(WORD_STEP));
        end
        default: ;
      endcase
    end
  end

  // Bus outputs decode only from registers, so they settle right after posedge and hold through negedge.
  always_comb begin
    mem.we_o      = 1'b0;
    mem.byte_op_o = 1'b0;
    mem.addr_o    = '0;
    mem.wd_o      = '0;
    unique case (state_q)
      RD: begin
        mem.addr_o    = src_q;
        mem.byte_op_o = byte_q;
      end
      WR: begin
        mem.addr_o    = dst_q;
        mem.byte_op_o = byte_q;
        mem.we_o      = 1'b1;
        mem.wd_o      = data_q;
      end
      default: ;
    endcase
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed bench for dma_copy_engine: a byte memory model serves the bus, expected writes
// are queued as each copy is launched and a negedge monitor pops and compares them.
module tb_dma_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] src_i = '0;
  logic [31:0] dst_i = '0;
  logic [15:0] len_i = '0;
  logic        busy_o, done_o, err_o;

  dma_copy_engine_if #(.DATA_WIDTH(32)) bus ();

  dma_copy_engine #(
    .DATA_WIDTH   (32),
    .BYTE_WIDTH   (8),
    .START_ADDRESS(32'h10000),
    .END_ADDRESS  (32'h1FFFF),
    .LEN_WIDTH    (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start_i),
    .src_i  (src_i),
    .dst_i  (dst_i),
    .len_i  (len_i),
    .busy_o (busy_o),
    .done_o (done_o),
    .err_o  (err_o),
    .mem    (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        byte_op;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  // Byte-addressed memory model, little-endian words, writes commit on negedge.
  logic [7:0]  mem [0:131071];
  logic        pl_we = 1'b0;
  logic [16:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  wire  [16:0] ra = bus.addr_o[16:0];

  assign bus.rd_i = bus.byte_op_o ? {24'h0, mem[ra]}
                                  : {mem[ra + 17'd3], mem[ra + 17'd2], mem[ra + 17'd1], mem[ra]};

  always @(negedge clk) begin
    if (bus.we_o) begin
      if (bus.byte_op_o) begin
        mem[ra] <= bus.wd_o[7:0];
      end else begin
        mem[ra]          <= bus.wd_o[7:0];
        mem[ra + 17'd1]  <= bus.wd_o[15:8];
        mem[ra + 17'd2]  <= bus.wd_o[23:16];
        mem[ra + 17'd3]  <= bus.wd_o[31:24];
      end
    end
    if (pl_we) mem[pl_addr] <= pl_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.we_o) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", bus.addr_o, bus.wd_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", bus.addr_o, e.addr);
        check("wr_byte_op", {31'b0, bus.byte_op_o}, {31'b0, e.byte_op});
        check("wr_data", bus.byte_op_o ? {24'h0, bus.wd_o[7:0]} : bus.wd_o, e.data);
      end
    end
  end

  task automatic poke(input logic [31:0] addr, input logic [7:0] data);
    pl_addr = addr[16:0];
    pl_data = data;
    pl_we   = 1'b1;
    @(negedge clk);
    #1 pl_we = 1'b0;
  endtask

  task automatic fill_dst(input logic [31:0] base);
    for (int i = 0; i < 16; i++) poke(base + 32'(i), 8'hEE);
  endtask

  task automatic push_wr(input logic [31:0] addr, input logic byte_op, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.byte_op = byte_op;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Presents start for one cycle; returns #1 after the accepting edge (cycle 1 of the transfer).
  task automatic launch(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len);
    @(posedge clk);
    #1;
    src_i   = src;
    dst_i   = dst;
    len_i   = len;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input int cyc0, output int cyc);
    cyc = cyc0;
    while (!done_o && cyc < 64) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("done_seen", {31'b0, done_o}, 32'd1);
  endtask

  task automatic check_copy1(input string tag);
    for (int i = 0; i < 8; i++)
      check(tag, {24'h0, mem[17'h10100 + 17'(i)]}, 32'(i + 1));
  endtask

  int cyc;
  int done_cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) poke(32'h10000 + 32'(i), 8'(i + 1));
    fill_dst(32'h10100);

    // Reset state
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_err", {31'b0, err_o}, 32'd0);
    check("rst_we", {31'b0, bus.we_o}, 32'd0);
    check("rst_byte_op", {31'b0, bus.byte_op_o}, 32'd0);
    check("rst_addr", bus.addr_o, 32'd0);
    check("rst_wd", bus.wd_o, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: aligned copy, two word pairs
    push_wr(32'h10100, 1'b0, 32'h04030201);
    push_wr(32'h10104, 1'b0, 32'h08070605);
    launch(32'h10000, 32'h10100, 16'd8);
    check("t1_busy", {31'b0, busy_o}, 32'd1);
    wait_done(1, cyc);
    check("t1_latency", cyc, 32'd5);
    check("t1_err", {31'b0, err_o}, 32'd0);
    @(posedge clk);
    #1 check("t1_done_pulse", {31'b0, done_o}, 32'd0);
    check("t1_queue", exp_q.size(), 32'd0);
    check_copy1("t1_mem");

    // 2: one word pair then two byte pairs
    fill_dst(32'h10100);
    push_wr(32'h10100, 1'b0, 32'h04030201);
    push_wr(32'h10104, 1'b1, 32'h05);
    push_wr(32'h10105, 1'b1, 32'h06);
    launch(32'h10000, 32'h10100, 16'd6);
    wait_done(1, cyc);
    check("t2_latency", cyc, 32'd7);
    check("t2_queue", exp_q.size(), 32'd0);
    check("t2_b5", {24'h0, mem[17'h10104]}, 32'h05);
    check("t2_b6", {24'h0, mem[17'h10105]}, 32'h06);
    check("t2_after", {24'h0, mem[17'h10106]}, 32'hEE);

    // 3: misaligned destination forces byte pairs
    fill_dst(32'h10100);
    for (int i = 0; i < 4; i++) push_wr(32'h10102 + 32'(i), 1'b1, 32'(i + 1));
    launch(32'h10000, 32'h10102, 16'd4);
    wait_done(1, cyc);
    check("t3_latency", cyc, 32'd9);
    check("t3_queue", exp_q.size(), 32'd0);
    check("t3_below", {24'h0, mem[17'h10101]}, 32'hEE);
    check("t3_above", {24'h0, mem[17'h10106]}, 32'hEE);
    for (int i = 0; i < 4; i++) check("t3_mem", {24'h0, mem[17'h10102 + 17'(i)]}, 32'(i + 1));

    // 4: range error, sticky err, then cleared by a good start
    launch(32'h10000, 32'h1FFFE, 16'd4);
    wait_done(1, cyc);
    check("t4_latency", cyc, 32'd1);
    check("t4_err", {31'b0, err_o}, 32'd1);
    @(posedge clk);
    #1 check("t4_err_sticky", {31'b0, err_o}, 32'd1);
    launch(32'h10000, 32'h10002, 16'd4);
    wait_done(1, cyc);
    check("t4_overlap_latency", cyc, 32'd1);
    check("t4_overlap_err", {31'b0, err_o}, 32'd1);
    push_wr(32'h10200, 1'b0, 32'h04030201);
    launch(32'h10000, 32'h10200, 16'd4);
    check("t4_err_clear", {31'b0, err_o}, 32'd0);
    wait_done(1, cyc);
    check("t4_good_latency", cyc, 32'd3);
    check("t4_queue", exp_q.size(), 32'd0);

    // 5: zero length, then a start pulse while busy
    launch(32'h10000, 32'h10100, 16'd0);
    wait_done(1, cyc);
    check("t5_zero_latency", cyc, 32'd1);
    check("t5_zero_err", {31'b0, err_o}, 32'd0);
    push_wr(32'h10300, 1'b0, 32'h04030201);
    push_wr(32'h10304, 1'b0, 32'h08070605);
    launch(32'h10000, 32'h10300, 16'd8);
    @(posedge clk);
    #1;
    src_i   = 32'h10004;
    dst_i   = 32'h10400;
    len_i   = 16'd4;
    start_i = 1'b1;
    check("t5_busy", {31'b0, busy_o}, 32'd1);
    @(posedge clk);
    #1 start_i = 1'b0;
    wait_done(3, cyc);
    check("t5_latency", cyc, 32'd5);
    done_cnt = 0;
    repeat (8) begin
      @(posedge clk);
      #1 if (done_o) done_cnt++;
    end
    check("t5_extra_done", done_cnt, 32'd0);
    check("t5_idle", {31'b0, busy_o}, 32'd0);
    check("t5_queue", exp_q.size(), 32'd0);

    // 6: reset during WR abandons the copy at once
    fill_dst(32'h10100);
    launch(32'h10000, 32'h10100, 16'd8);
    @(posedge clk);
    #1 check("t6_in_wr", {31'b0, bus.we_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_we", {31'b0, bus.we_o}, 32'd0);
    check("t6_busy", {31'b0, busy_o}, 32'd0);
    check("t6_addr", bus.addr_o, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    done_cnt = 0;
    repeat (4) begin
      @(posedge clk);
      #1 if (done_o || busy_o) done_cnt++;
    end
    check("t6_idle", done_cnt, 32'd0);
    check("t6_untouched", {24'h0, mem[17'h10100]}, 32'hEE);
    push_wr(32'h10100, 1'b0, 32'h04030201);
    push_wr(32'h10104, 1'b0, 32'h08070605);
    launch(32'h10000, 32'h10100, 16'd8);
    wait_done(1, cyc);
    check("t6_latency", cyc, 32'd5);
    @(posedge clk);
    #1 check("t6_queue", exp_q.size(), 32'd0);
    check_copy1("t6_mem");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
